// File: rtl/seq_mult.sv
// Iterative shift-add multiplier, one partial product per clock.
// Signed mode subtracts the partial product of a's sign bit.
module seq_mult #(
    parameter int A_WIDTH = 4,
    parameter int B_WIDTH = 6,
    parameter int P_WIDTH = A_WIDTH + B_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [A_WIDTH-1:0] a,
    input  logic [B_WIDTH-1:0] b,
    output logic               busy,
    output logic               done,
    output logic [P_WIDTH-1:0] p
);

    localparam int CW = $clog2(A_WIDTH);
    localparam int XW = P_WIDTH - B_WIDTH;
    localparam logic [CW-1:0] LAST = CW'(A_WIDTH - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [A_WIDTH-1:0] a_q;
    logic [P_WIDTH-1:0] b_ext;
    logic               sm_q;
    logic [P_WIDTH-1:0] acc;
    logic [P_WIDTH-1:0] pp;
    logic [P_WIDTH-1:0] acc_next;
    logic [P_WIDTH-1:0] b_cap;
    logic               last;

    // Extension is resolved once at capture so the loop only shifts.
    always_comb begin
        b_cap = {{XW{signed_mode & b[B_WIDTH-1]}}, b};
    end

    always_comb begin
        last     = (cnt == LAST);
        pp       = a_q[cnt] ? (b_ext << cnt) : '0;
        acc_next = (sm_q && last) ? (acc - pp) : (acc + pp);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            p     <= '0;
            cnt   <= '0;
            acc   <= '0;
            a_q   <= '0;
            b_ext <= '0;
            sm_q  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        b_ext <= b_cap;
                        sm_q  <= signed_mode;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        p     <= acc_next;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        cnt   <= '0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult.sv
// Directed and random checks of seq_mult at 4x6 and 8x8 widths.
module tb_seq_mult;

    logic       clk;
    logic       rst_n;

    logic       start4;
    logic       sm4;
    logic [3:0] a4;
    logic [5:0] b4;
    logic       busy4;
    logic       done4;
    logic [9:0] p4;

    logic        start8;
    logic        sm8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        busy8;
    logic        done8;
    logic [15:0] p8;

    int n_chk;
    int n_fail;

    seq_mult u_dut4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start4),
        .signed_mode (sm4),
        .a           (a4),
        .b           (b4),
        .busy        (busy4),
        .done        (done4),
        .p           (p4)
    );

    seq_mult #(
        .A_WIDTH (8),
        .B_WIDTH (8)
    ) u_dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start8),
        .signed_mode (sm8),
        .a           (a8),
        .b           (b8),
        .busy        (busy8),
        .done        (done8),
        .p           (p8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic op4(input string tag, input logic sm,
                       input logic [3:0] aa, input logic [5:0] bb,
                       input logic [9:0] exp);
        logic early;
        early  = 1'b0;
        sm4    = sm;
        a4     = aa;
        b4     = bb;
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        sm4    = ~sm;
        a4     = ~aa;
        b4     = ~bb;
        check({tag, "_busy"}, 32'(busy4), 1);
        repeat (3) begin
            @(posedge clk); #1;
            early = early | done4 | ~busy4;
        end
        @(posedge clk); #1;
        check({tag, "_early"}, 32'(early), 0);
        check({tag, "_done"}, 32'({done4, busy4}), 2);
        check({tag, "_p"}, 32'(p4), 32'(exp));
        @(posedge clk); #1;
        check({tag, "_pulse"}, 32'({done4, busy4}), 0);
        check({tag, "_hold"}, 32'(p4), 32'(exp));
    endtask

    task automatic op8(input string tag, input logic sm,
                       input logic [7:0] aa, input logic [7:0] bb,
                       input logic [15:0] exp);
        logic early;
        early  = 1'b0;
        sm8    = sm;
        a8     = aa;
        b8     = bb;
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        sm8    = ~sm;
        a8     = ~aa;
        b8     = ~bb;
        check({tag, "_busy"}, 32'(busy8), 1);
        repeat (7) begin
            @(posedge clk); #1;
            early = early | done8 | ~busy8;
        end
        @(posedge clk); #1;
        check({tag, "_early"}, 32'(early), 0);
        check({tag, "_done"}, 32'({done8, busy8}), 2);
        check({tag, "_p"}, 32'(p8), 32'(exp));
        @(posedge clk); #1;
        check({tag, "_pulse"}, 32'({done8, busy8}), 0);
    endtask

    initial begin
        logic flag;
        logic [3:0] ra4;
        logic [5:0] rb4;
        logic [7:0] ra8;
        logic [7:0] rb8;
        logic rsm;
        logic signed [9:0] sx4;
        logic signed [15:0] sx8;
        logic [9:0] e4;
        logic [15:0] e8;

        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        start4 = 1'b0;
        sm4    = 1'b0;
        a4     = '0;
        b4     = '0;
        start8 = 1'b0;
        sm8    = 1'b0;
        a8     = '0;
        b8     = '0;
        #12;
        check("in_reset", 32'({busy4, done4, p4}), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        repeat (20) begin
            check("idle4", 32'({busy4, done4, p4}), 0);
            check("idle8", 32'({busy8, done8, p8}), 0);
            @(posedge clk); #1;
        end

        op4("neg_neg", 1'b1, 4'b1000, 6'b100000, 10'h100);
        op4("neg1_1", 1'b1, 4'hF, 6'h01, 10'h3FF);
        op4("pos_pos", 1'b1, 4'd7, 6'd31, 10'h0D9);
        op4("uns_max", 1'b0, 4'hF, 6'h3F, 10'h3B1);
        op4("sgn_m1m1", 1'b1, 4'hF, 6'h3F, 10'h001);

        // Start while busy is dropped; held start is taken after done.
        a4 = 4'd3; b4 = 6'd5; sm4 = 1'b1; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        check("ign_busy0", 32'(busy4), 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        start4 = 1'b1; a4 = 4'd7; b4 = 6'd7;
        @(posedge clk); #1;
        check("ign_mid", 32'({done4, busy4}), 1);
        @(posedge clk); #1;
        check("ign_done", 32'({done4, busy4}), 2);
        check("ign_p", 32'(p4), 'h00F);
        @(posedge clk); #1;
        check("b2b_acc", 32'({done4, busy4}), 1);
        check("b2b_hold", 32'(p4), 'h00F);
        start4 = 1'b0; a4 = '0; b4 = '0;
        flag = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            flag = flag | done4;
        end
        check("b2b_nodone", 32'(flag), 0);
        @(posedge clk); #1;
        check("b2b_done", 32'({done4, busy4}), 2);
        check("b2b_p", 32'(p4), 'h031);

        // Asynchronous reset in the middle of an operation.
        a4 = 4'd5; b4 = 6'd3; sm4 = 1'b0; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #3 rst_n = 1'b0;
        #1;
        check("arst", 32'({busy4, done4, p4}), 0);
        #1 rst_n = 1'b1;
        flag = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            flag = flag | done4 | busy4;
        end
        check("arst_quiet", 32'(flag), 0);
        op4("post_rst", 1'b1, 4'hE, 6'h05, 10'h3F6);

        op8("w8_sgn", 1'b1, 8'h80, 8'h80, 16'h4000);
        op8("w8_uns", 1'b0, 8'hFF, 8'hFF, 16'hFE01);
        op8("w8_mix", 1'b1, 8'h7F, 8'h80, 16'hC080);

        for (int i = 0; i < 1000; i++) begin
            ra4 = 4'($urandom);
            rb4 = 6'($urandom);
            rsm = 1'($urandom);
            if (rsm) begin
                sx4 = $signed({{6{ra4[3]}}, ra4}) * $signed({{4{rb4[5]}}, rb4});
                e4  = sx4;
            end else begin
                e4 = {6'b0, ra4} * {4'b0, rb4};
            end
            op4("rnd4", rsm, ra4, rb4, e4);
        end

        for (int i = 0; i < 1000; i++) begin
            ra8 = 8'($urandom);
            rb8 = 8'($urandom);
            rsm = 1'($urandom);
            if (rsm) begin
                sx8 = $signed({{8{ra8[7]}}, ra8}) * $signed({{8{rb8[7]}}, rb8});
                e8  = sx8;
            end else begin
                e8 = {8'b0, ra8} * {8'b0, rb8};
            end
            op8("rnd8", rsm, ra8, rb8, e8);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_mult.md
Name: seq_mult

Overview:
- Parametrised iterative multiplier: one partial product per clock, two's-complement (Baugh-Wooley-equivalent) or unsigned mode selected per operation.
- Generalises the team's fixed 6x4 combinational signed multiplier to arbitrary operand widths, adds a start/done handshake and a registered result.
- Sits in the datapath wherever area matters more than single-cycle latency.

Parameters:
- A_WIDTH, 4, multiplier operand width (one iteration per bit), >= 2
- B_WIDTH, 6, multiplicand operand width, >= 2
- P_WIDTH, A_WIDTH+B_WIDTH, product width (derived; do not override)

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; accepted only when busy=0
- signed_mode  input  1  1 = a, b two's complement; 0 = unsigned; captured with start
- a  input  A_WIDTH  multiplier, captured with start
- b  input  B_WIDTH  multiplicand, captured with start
- busy  output  1  high while an operation is in progress
- done  output  1  single-cycle pulse: p holds a new result
- p  output  P_WIDTH  registered product, held until next done

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset (rst_n=0, any time, including mid-operation): state=IDLE, busy=0, done=0, p=0, counter=0, accumulator=0; in-flight operation discarded, no done produced.
- States: IDLE, RUN.
- IDLE:
  - start=1 at edge k: capture a, b, signed_mode; clear accumulator; counter=0; go to RUN; busy=1 from edge k.
  - start=0: stay in IDLE.
- RUN: at each edge, for i=counter, add pp_i = a[i] ? b_ext : 0, shifted left by i, to the accumulator (P_WIDTH bits, modulo 2^P_WIDTH).
  - b_ext = b sign-extended to P_WIDTH if signed_mode, else zero-extended.
  - If signed_mode and i=A_WIDTH-1, pp_i is subtracted instead of added (weight of a's sign bit is negative).
  - counter increments.
  - At edge k+A_WIDTH (last bit): p <= final accumulator, done=1, busy=0, go to IDLE.
- Latency: start sampled at edge k, done high for exactly the cycle following edge k+A_WIDTH; busy high for exactly A_WIDTH cycles.
- done is high for exactly one cycle per accepted start.
- start while busy=1: ignored; captured operands unchanged, no queuing.
- start=1 in the done cycle: accepted, since state is IDLE; back-to-back throughput is one result per A_WIDTH cycles. done and busy may both be high in that cycle only if start was accepted at that same edge; otherwise done implies busy=0.
- Result is exact (full-width product cannot overflow P_WIDTH) in both modes:
  - signed: p = a*b as P_WIDTH two's complement.
  - unsigned: p = a*b.
- Inputs a, b, signed_mode may change freely after acceptance without affecting the result.
- p changes only at a done edge or at reset.

Test Plan:
- Reset release, no start, 20 cycles -> busy=0, done=0, p=10'h000 throughout.
- Defaults, signed_mode=1, a=4'b1000 (-8), b=6'b100000 (-32), start one cycle -> done exactly 4 cycles after acceptance edge, p=10'h100 (+256); then a=4'hF (-1), b=6'h01 -> p=10'h3FF (-1); then a=7, b=31 -> p=10'h0D9 (217).
- signed_mode=0, a=4'hF, b=6'h3F -> p=10'h3B1 (945); same bits with signed_mode=1 -> p=10'h001 (+1).
- Start accepted with a=3, b=5; start re-asserted 2 cycles later with a=7, b=7 -> second start ignored, p=10'h00F, one done pulse only. Start held high through the done cycle -> new operation accepted there, second done 4 cycles later.
- rst_n pulsed low (asynchronously, mid-cycle) 2 cycles into an operation -> busy, done, p drop to 0 immediately; no done after release; next start yields correct result.
- Randomised: A_WIDTH=8, B_WIDTH=8 plus default widths, 1000 random operands in both modes -> p matches reference model every time, latency fixed at A_WIDTH.
